uart: RTL and testbench



---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_rx.sv | 126 ++++++++++++
 rtl/uart_tx.sv | 115 +++++++++++
 rtl/uart.sv | 58 +++++
 tb/tb_uart.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transceiver.
//   parity_mode_e : parity-mode encoding (odd, even, none)
//   tx_state_e    : transmit FSM states
//   rx_state_e    : receive FSM states
//   parity_bit()  : parity bit to send/expect for a data byte in a given mode
package uart_pkg;

    typedef enum logic [1:0] {
        ParOdd,
        ParEven,
        ParNone
    } parity_mode_e;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop
    } rx_state_e;

    // Odd mode makes the total count of ones (data + parity) odd.
    function automatic logic parity_bit(input logic [7:0] data, input parity_mode_e mode);
        case (mode)
            ParOdd:  return ~^data;
            ParEven: return ^data;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: deserialises frames from an asynchronous serial line.
// The line is double-flopped, the start bit is re-checked at mid-bit, and each following bit
// is sampled at its mid-point. Only frames with a good stop bit and parity update the output.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   rx    in   serial line, asynchronous to clk
//   data  out  last valid received byte
//   rdy   out  data holds a valid, unacknowledged byte
//   ack   in   consumer acknowledge for rdy
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned  CLKS_PER_BIT = 434,
    parameter parity_mode_e MODE         = ParOdd
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rdy,
    input  logic       ack
);

    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_ok;
    logic          rx_meta;
    logic          rx_sync;
    logic          bit_done;

    assign bit_done = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RxIdle;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
            data    <= '0;
            rdy     <= 1'b0;
        end else begin
            // Placed before the FSM so a same-cycle load overrides the clear.
            if (rdy && ack) begin
                rdy <= 1'b0;
            end

            case (state)
                RxIdle: begin
                    cnt <= '0;
                    if (!rx_sync) begin
                        state <= RxStart;
                    end
                end

                RxStart: begin
                    // Mid-bit re-check rejects glitches shorter than half a bit.
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RxIdle : RxData;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RxData: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            par_ok <= 1'b1;
                            state  <= (MODE == ParNone) ? RxStop : RxParity;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RxParity: begin
                    if (bit_done) begin
                        cnt    <= '0;
                        par_ok <= (rx_sync == parity_bit(shreg, MODE));
                        state  <= RxStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                RxStop: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (rx_sync && par_ok) begin
                            data <= shreg;
                            rdy  <= 1'b1;
                        end
                        state <= RxIdle;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per accepted request.
// Frame: start(0), 8 data bits LSB first, optional parity, stop(1); each bit CLKS_PER_BIT cycles.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   data  in   byte to send, sampled on acceptance
//   req   in   transmit request (level)
//   ack   out  one-cycle pulse the cycle after a request is accepted
//   tx    out  serial line, idles high
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned  CLKS_PER_BIT = 434,
    parameter parity_mode_e MODE         = ParOdd
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       req,
    output logic       ack,
    output logic       tx
);

    localparam int unsigned   CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_done;

    assign bit_done = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TxIdle;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            ack     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            ack <= 1'b0;
            if (state != TxIdle) begin
                cnt <= bit_done ? '0 : cnt + 1'b1;
            end

            case (state)
                TxIdle: begin
                    if (req) begin
                        shreg <= data;
                        ack   <= 1'b1;
                        tx    <= 1'b0;
                        state <= TxStart;
                    end else begin
                        tx <= 1'b1;
                    end
                end

                TxStart: begin
                    if (bit_done) begin
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        state   <= TxData;
                    end
                end

                TxData: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
                            if (MODE == ParNone) begin
                                tx    <= 1'b1;
                                state <= TxStop;
                            end else begin
                                tx    <= parity_bit(shreg, MODE);
                                state <= TxParity;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end
                end

                TxParity: begin
                    if (bit_done) begin
                        tx    <= 1'b1;
                        state <= TxStop;
                    end
                end

                TxStop: begin
                    // A pending request is taken on the last stop-bit edge so that
                    // back-to-back frames have no idle gap.
                    if (bit_done) begin
                        state <= TxIdle;
                        if (req) begin
                            shreg <= data;
                            ack   <= 1'b1;
                            tx    <= 1'b0;
                            state <= TxStart;
                        end
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= TxIdle;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart.sv
// uart: full-duplex 8-bit UART; thin wrapper around independent transmit and receive halves.
// Ports:
//   inclk    in   system clock
//   rst      in   synchronous active-high reset
//   tx_data  in   byte to transmit
//   tx_req   in   transmit request (level)
//   tx_ack   out  one-cycle pulse: tx_data accepted
//   tx       out  serial output, idles high
//   rx       in   serial input
//   rx_data  out  last received byte
//   rx_rdy   out  rx_data valid and unacknowledged
//   rx_ack   in   acknowledge for rx_rdy
module uart
    import uart_pkg::*;
#(
    parameter string       PARITY       = "ODD",
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       inclk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       tx_ack,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       rx_ack
);

    localparam parity_mode_e MODE = (PARITY == "NONE") ? ParNone :
                                    (PARITY == "EVEN") ? ParEven : ParOdd;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .MODE        (MODE)
    ) u_tx (
        .clk (inclk),
        .rst (rst),
        .data(tx_data),
        .req (tx_req),
        .ack (tx_ack),
        .tx  (tx)
    );

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .MODE        (MODE)
    ) u_rx (
        .clk (inclk),
        .rst (rst),
        .rx  (rx),
        .data(rx_data),
        .rdy (rx_rdy),
        .ack (rx_ack)
    );

endmodule

// File: tb/tb_uart.sv
// tb_uart: self-checking bench for uart (ODD parity, 16 clocks per bit).
// Frames are checked bit-by-bit against a model built from the frame format; received bytes
// are checked against a queue of transmitted bytes when tx is looped back to rx.
module tb_uart;

    localparam int N = 16;

    logic       inclk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ack;
    logic       tx;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_ack;
    logic       loop;
    logic       rx_drv;

    assign rx = loop ? tx : rx_drv;

    uart #(
        .PARITY      ("ODD"),
        .CLKS_PER_BIT(N)
    ) dut (
        .inclk  (inclk),
        .rst    (rst),
        .tx_data(tx_data),
        .tx_req (tx_req),
        .tx_ack (tx_ack),
        .tx     (tx),
        .rx     (rx),
        .rx_data(rx_data),
        .rx_rdy (rx_rdy),
        .rx_ack (rx_ack)
    );

    always #5 inclk = ~inclk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] exp_q[$];
    logic [7:0] rnd[20];
    logic [7:0] last_rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge inclk);
        #1;
    endtask

    // ODD parity: the parity bit makes the total number of ones odd.
    function automatic logic model_parity(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    function automatic logic model_bit(input logic [7:0] d, input logic par, input logic stop,
                                       input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9) return par;
        return stop;
    endfunction

    // Entered at the first start-bit cycle; checks one full frame of d on tx. Optionally raises
    // the next request one cycle after acceptance (streaming requester).
    task automatic check_frame(input logic [7:0] d, input logic par, input logic nxt_v,
                               input logic [7:0] nxt_d, output int rx_cnt, output int rx_first,
                               output logic [7:0] rx_byte);
        int   bad;
        int   ack_extra;
        logic expb;
        rx_cnt    = 0;
        rx_first  = -1;
        rx_byte   = 8'h00;
        ack_extra = 0;
        check($sformatf("accept_ack_%02h", d), {31'd0, tx_ack}, 1);
        check($sformatf("start_edge_%02h", d), {31'd0, tx}, 0);
        tx_req = 1'b0;
        for (int b = 0; b < 11; b++) begin
            expb = model_bit(d, par, 1'b1, b);
            bad  = 0;
            for (int c = 0; c < N; c++) begin
                int cyc;
                cyc = b * N + c;
                if (tx !== expb) bad++;
                if (cyc > 0 && tx_ack === 1'b1) ack_extra++;
                if (rx_rdy === 1'b1) begin
                    if (rx_cnt == 0) rx_first = cyc;
                    rx_cnt++;
                    rx_byte = rx_data;
                end
                if (cyc == 1 && nxt_v) begin
                    tx_data = nxt_d;
                    tx_req  = 1'b1;
                end
                step();
            end
            check($sformatf("bit%0d_of_%02h_bad_cycles", b, d), bad, 0);
        end
        check($sformatf("ack_in_frame_%02h", d), ack_extra, 0);
        if (!nxt_v) begin
            check("idle_tx_after_frame", {31'd0, tx}, 1);
            check("idle_ack_after_frame", {31'd0, tx_ack}, 0);
        end
    endtask

    // Drives one frame on rx with the given parity and stop bits, then idles 2 bits.
    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop,
                               output int rdy_hi);
        rdy_hi = 0;
        for (int b = 0; b < 11; b++) begin
            rx_drv = model_bit(d, par, stop, b);
            for (int c = 0; c < N; c++) begin
                if (rx_rdy === 1'b1) rdy_hi++;
                step();
            end
        end
        rx_drv = 1'b1;
        for (int c = 0; c < 2 * N; c++) begin
            if (rx_rdy === 1'b1) rdy_hi++;
            step();
        end
    endtask

    // Checks a loopback reception against the scoreboard.
    task automatic check_rx(input int rx_cnt, input int rx_first, input logic [7:0] rx_byte);
        logic [7:0] exp;
        exp = 8'h00;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check("rx_pulse_count", rx_cnt, 1);
        check("rx_pulse_not_before_stop", {31'd0, rx_first >= 10 * N}, 1);
        check("rx_byte", {24'd0, rx_byte}, {24'd0, exp});
        last_rx = exp;
    endtask

    initial begin
        int         rc;
        int         rf;
        int         hi;
        int         bad;
        logic [7:0] rb;

        tbl[0] = '{8'h01, 1'b0};
        tbl[1] = '{8'h02, 1'b0};
        tbl[2] = '{8'h03, 1'b1};
        tbl[3] = '{8'hA5, 1'b1};
        tbl[4] = '{8'hFF, 1'b1};
        tbl[5] = '{8'h00, 1'b1};
        tbl[6] = '{8'h80, 1'b0};
        tbl[7] = '{8'h3C, 1'b1};
        for (int i = 0; i < 20; i++) rnd[i] = 8'($urandom_range(0, 255));

        // Reset, with a request held high that must not be accepted.
        loop    = 1'b1;
        rx_drv  = 1'b1;
        rx_ack  = 1'b1;
        rst     = 1'b1;
        tx_req  = 1'b1;
        tx_data = 8'h55;
        last_rx = 8'h00;
        step();
        step();
        check("rst_tx", {31'd0, tx}, 1);
        check("rst_ack", {31'd0, tx_ack}, 0);
        tx_req = 1'b0;
        rst    = 1'b0;
        step();
        check("reset_tx", {31'd0, tx}, 1);
        check("reset_ack", {31'd0, tx_ack}, 0);
        check("reset_rx_rdy", {31'd0, rx_rdy}, 0);
        check("reset_rx_data", {24'd0, rx_data}, 0);
        step();
        check("no_latent_accept", {31'd0, tx_ack}, 0);

        // Table vectors, streamed back to back, looped back into rx.
        tx_data = tbl[0].data;
        tx_req  = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(tbl[i].data);
            check_frame(tbl[i].data, tbl[i].par, i < 7, (i < 7) ? tbl[(i+1)%8].data : 8'h00,
                        rc, rf, rb);
            check_rx(rc, rf, rb);
        end

        // Random bytes against the model.
        repeat (3) step();
        tx_data = rnd[0];
        tx_req  = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(rnd[i]);
            check_frame(rnd[i], model_parity(rnd[i]), i < 19, (i < 19) ? rnd[(i+1)%20] : 8'h00,
                        rc, rf, rb);
            check_rx(rc, rf, rb);
        end

        // Receive error cases with rx driven directly.
        loop = 1'b0;
        repeat (4) step();
        drive_frame(8'hA5, ~model_parity(8'hA5), 1'b1, hi);
        check("parity_err_rdy", hi, 0);
        check("parity_err_data", {24'd0, rx_data}, {24'd0, last_rx});
        drive_frame(8'hA5, model_parity(8'hA5), 1'b0, hi);
        check("stop_err_rdy", hi, 0);
        check("stop_err_data", {24'd0, rx_data}, {24'd0, last_rx});
        rx_drv = 1'b0;
        step();
        rx_drv = 1'b1;
        hi = 0;
        for (int c = 0; c < 2 * N; c++) begin
            if (rx_rdy === 1'b1) hi++;
            step();
        end
        check("glitch_rdy", hi, 0);
        check("glitch_data", {24'd0, rx_data}, {24'd0, last_rx});
        drive_frame(8'hC3, model_parity(8'hC3), 1'b1, hi);
        check("good_after_errors_pulses", hi, 1);
        check("good_after_errors_data", {24'd0, rx_data}, 8'hC3);

        // Hold with no acknowledge, overrun, then acknowledge.
        rx_ack = 1'b0;
        drive_frame(8'h3C, model_parity(8'h3C), 1'b1, hi);
        check("hold_rdy", {31'd0, rx_rdy}, 1);
        check("hold_data", {24'd0, rx_data}, 8'h3C);
        repeat (20) step();
        check("hold_rdy_later", {31'd0, rx_rdy}, 1);
        drive_frame(8'h5A, model_parity(8'h5A), 1'b1, hi);
        check("overrun_rdy", {31'd0, rx_rdy}, 1);
        check("overrun_data", {24'd0, rx_data}, 8'h5A);
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
        check("ack_clears_rdy", {31'd0, rx_rdy}, 0);
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
        check("ack_without_rdy", {31'd0, rx_rdy}, 0);
        check("ack_without_rdy_data", {24'd0, rx_data}, 8'h5A);

        // Reset in the middle of a transmit frame.
        tx_data = 8'h00;
        tx_req  = 1'b1;
        step();
        check("midrst_accept", {31'd0, tx_ack}, 1);
        tx_req = 1'b0;
        repeat (3 * N) step();
        check("midrst_frame_low", {31'd0, tx}, 0);
        rst = 1'b1;
        step();
        check("midrst_tx_high", {31'd0, tx}, 1);
        check("midrst_ack", {31'd0, tx_ack}, 0);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 2 * N; c++) begin
            if (tx !== 1'b1 || tx_ack !== 1'b0) bad++;
            step();
        end
        check("midrst_stays_idle", bad, 0);
        tx_data = 8'h96;
        tx_req  = 1'b1;
        step();
        check_frame(8'h96, model_parity(8'h96), 1'b0, 8'h00, rc, rf, rb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "timeout");
    end

endmodule
